// File: rtl/gpi_axi_master_pkg.sv
// Shared AXI3 constants, response helpers and FSM encoding for the single-outstanding
// peripheral-to-AXI3 master.
package gpi_axi_master_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam axi_resp_t  AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t  AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t  AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t  AXI_RESP_DECERR = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_DATA = ST_RD_DATA,
    S_WR_REQ  = ST_WR_REQ,
    S_WR_RESP = ST_WR_RESP,
    S_DONE    = ST_DONE
  } state_e;

  // SLVERR and DECERR both report as an error; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input axi_resp_t resp);
    logic err;
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
      default:                          err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/gpi_axi_master_if.sv
// AXI3 master/slave bus bundle (32-bit data, 6-bit ids) used by gpi_axi_master.
interface gpi_axi_master_if;
  import gpi_axi_master_pkg::*;

  logic [5:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [5:0]  rid;
  logic [31:0] rdata;
  axi_resp_t   rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [5:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [5:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [5:0]  bid;
  axi_resp_t   bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/gpi_axi_master.sv
// Single-outstanding AXI3 master: one-beat peripheral read/write requests become
// single-beat INCR bursts; one completion pulse per request.
module gpi_axi_master
  import gpi_axi_master_pkg::*;
#(
  parameter logic [5:0] AXI_ID    = 6'd0,
  parameter logic [3:0] AXI_CACHE = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  gpi_axi_master_if.master axi
);

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_hs, w_hs;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    aw_hs        = awvalid_q & axi.awready;
    w_hs         = wvalid_q & axi.wready;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          size_d      = req_size;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          req_ready_d = 1'b0;
          if (req_write) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (axi.rvalid) begin
          rready_d     = 1'b0;
          resp_rdata_d = axi.rdata;
          resp_err_d   = resp_is_err(axi.rresp);
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_WR_REQ: begin
        // AW and W channels retire independently; the B phase opens once both have.
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi.bvalid) begin
          bready_d     = 1'b0;
          resp_err_d   = resp_is_err(axi.bresp);
          resp_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
      end
    endcase
  end

  // Request payload latches carry no reset; they are only observed while a valid is up.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = size_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = AXI_CACHE;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = size_q;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = AXI_CACHE;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // With one transaction in flight, response ids and rlast carry no information.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{axi.rid, axi.rlast, axi.bid};

endmodule

// File: tb/tb_gpi_axi_master.sv
// Bench for gpi_axi_master: randomized slave timing and requests, a transaction-phase
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_gpi_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  gpi_axi_master_if axi();

  gpi_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- slave knobs (-1 = random per transaction) ----------------
  int          k_ar = 0, k_r = 0, k_aw = 0, k_w = 0, k_b = 0;
  int          k_rresp = 0, k_bresp = 0;
  bit          k_rdata_en = 1'b0;
  logic [31:0] k_rdata = 32'd0;

  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0, n_acc = 0;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [7:0]  last_arlen;

  function automatic int pick(input int k);
    return (k < 0) ? int'($urandom_range(0, 3)) : k;
  endfunction

  function automatic logic [1:0] pick_resp(input int k);
    if (k >= 0) return 2'(k);
    return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endfunction

  // ---------------- slave: samples at negedge, drives just after posedge ----------------
  initial begin
    int ar_cnt, ar_cur, aw_cnt, aw_cur, w_cnt, w_cur, r_cnt, b_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    bit s_rst, s_ar, s_r, s_aw, s_w, s_b, s_arv, s_awv, s_wv;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [7:0]  s_arlen;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    ar_cur = 0; aw_cur = 0; w_cur = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00; axi.rid = 6'd0; axi.rlast = 1'b1;
    axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 6'd0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_arv = axi.arvalid; s_awv = axi.awvalid; s_wv = axi.wvalid;
      s_ar = axi.arvalid & axi.arready;
      s_r  = axi.rvalid & axi.rready;
      s_aw = axi.awvalid & axi.awready;
      s_w  = axi.wvalid & axi.wready;
      s_b  = axi.bvalid & axi.bready;
      s_araddr = axi.araddr; s_arlen = axi.arlen;
      s_awaddr = axi.awaddr; s_wdata = axi.wdata;
      @(posedge clk);
      #1;
      if (s_rst) begin
        axi.rvalid = 1'b0; axi.bvalid = 1'b0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        ar_cur = pick(k_ar); aw_cur = pick(k_aw); w_cur = pick(k_w);
      end else begin
        if (s_ar) begin
          n_ar++; last_araddr = s_araddr; last_arlen = s_arlen;
          r_pend = 1; r_cnt = pick(k_r);
        end
        if (s_ar || !s_arv) begin ar_cnt = 0; ar_cur = pick(k_ar); end else ar_cnt++;
        if (s_aw) begin n_aw++; last_awaddr = s_awaddr; aw_got = 1; end
        if (s_aw || !s_awv) begin aw_cnt = 0; aw_cur = pick(k_aw); end else aw_cnt++;
        if (s_w) begin n_w++; last_wdata = s_wdata; w_got = 1; end
        if (s_w || !s_wv) begin w_cnt = 0; w_cur = pick(k_w); end else w_cnt++;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = pick(k_b);
        end
        if (s_r) axi.rvalid = 1'b0;
        if (s_b) begin axi.bvalid = 1'b0; n_b++; end
        if (r_pend && !axi.rvalid) begin
          if (r_cnt == 0) begin
            axi.rvalid = 1'b1;
            axi.rdata  = k_rdata_en ? k_rdata : $urandom;
            axi.rresp  = pick_resp(k_rresp);
            r_pend = 0;
          end else r_cnt--;
        end
        if (b_pend && !axi.bvalid) begin
          if (b_cnt == 0) begin
            axi.bvalid = 1'b1;
            axi.bresp  = pick_resp(k_bresp);
            b_pend = 0;
          end else b_cnt--;
        end
      end
      axi.arready = (ar_cnt >= ar_cur);
      axi.awready = (aw_cnt >= aw_cur);
      axi.wready  = (w_cnt >= w_cur);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    bit m_init, m_busy, m_write, m_ar, m_aw, m_w, m_fin, m_err;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_size;
    logic [3:0]  m_wstrb;
    bit e_arv, e_rr, e_awv, e_wv, e_br;
    m_init = 0; m_busy = 0; m_write = 0; m_ar = 0; m_aw = 0; m_w = 0; m_fin = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_size = 0; m_wstrb = 0;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) n_resp++;
      e_arv = m_busy && !m_write && !m_ar;
      e_rr  = m_busy && !m_write && m_ar && !m_fin;
      e_awv = m_busy && m_write && !m_aw;
      e_wv  = m_busy && m_write && !m_w;
      e_br  = m_busy && m_write && m_aw && m_w && !m_fin;
      if (m_init) begin
        chk("req_ready", 32'(req_ready), 32'(!m_busy));
        chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_fin));
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("arvalid", 32'(axi.arvalid), 32'(e_arv));
        chk("rready", 32'(axi.rready), 32'(e_rr));
        chk("awvalid", 32'(axi.awvalid), 32'(e_awv));
        chk("wvalid", 32'(axi.wvalid), 32'(e_wv));
        chk("bready", 32'(axi.bready), 32'(e_br));
        if (e_arv) begin
          chk("araddr", axi.araddr, m_addr);
          chk("arsize", 32'(axi.arsize), 32'(m_size));
          chk("ar_const", {axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
              {6'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        end
        if (e_awv) begin
          chk("awaddr", axi.awaddr, m_addr);
          chk("awsize", 32'(axi.awsize), 32'(m_size));
          chk("aw_const", {axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
              {6'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
        end
        if (e_wv) begin
          chk("wdata", axi.wdata, m_wdata);
          chk("w_misc", {axi.wid, axi.wstrb, axi.wlast}, {21'd0, 6'd0, m_wstrb, 1'b1});
        end
      end
      // advance the model to the state after the coming edge
      if (rst) begin
        m_init = 1; m_busy = 0; m_fin = 0; m_rdata = 0; m_err = 0;
      end else if (m_init) begin
        if (!m_busy) begin
          if (req_valid) begin
            n_acc++;
            m_busy = 1; m_fin = 0; m_ar = 0; m_aw = 0; m_w = 0;
            m_write = req_write; m_addr = req_addr; m_size = req_size;
            m_wdata = req_wdata; m_wstrb = req_wstrb;
          end
        end else if (m_fin) begin
          m_busy = 0; m_fin = 0;
        end else if (!m_write) begin
          if (e_arv && axi.arready) m_ar = 1;
          else if (e_rr && axi.rvalid) begin
            m_fin = 1; m_rdata = axi.rdata; m_err = axi.rresp[1];
          end
        end else begin
          if (e_br) begin
            if (axi.bvalid) begin m_fin = 1; m_err = axi.bresp[1]; end
          end else begin
            if (e_awv && axi.awready) m_aw = 1;
            if (e_wv && axi.wready) m_w = 1;
          end
        end
      end
    end
  end

  // ---------------- request driver ----------------
  bit hold_valid = 1'b0;

  task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, input logic [3:0] st, output int acc);
    @(posedge clk);
    #1;
    req_write = w; req_addr = a; req_size = s; req_wdata = d; req_wstrb = st;
    req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int rc);
    rc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_knobs(input int ar, input int r, input int aw, input int w, input int b);
    k_ar = ar; k_r = r; k_aw = aw; k_w = w; k_b = b;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got cycle %0d want finish", cyc);
    $fatal(1);
  end

  // ---------------- directed scenarios then random traffic ----------------
  initial begin
    int acc, rc, prev, gap_ok, a0, w0, b0, r0, acc0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_size = 0; req_wdata = 0; req_wstrb = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_rdata", resp_rdata, 32'd0);

    // zero-wait read
    set_knobs(0, 0, 0, 0, 0);
    k_rresp = 0; k_bresp = 0; k_rdata_en = 1; k_rdata = 32'hDEAD_BEEF;
    do_req(1'b0, 32'h1000_0100, 3'd2, 32'd0, 4'd0, acc);
    wait_resp(rc);
    chk("rd_latency", 32'(rc - acc), 32'd3);
    chk("rd_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("rd_err", 32'(resp_err), 32'd0);
    chk("rd_araddr", last_araddr, 32'h1000_0100);
    chk("rd_arlen", 32'(last_arlen), 32'd0);

    // write with awready three cycles ahead of wready
    a0 = n_aw; w0 = n_w; b0 = n_b; r0 = n_resp;
    set_knobs(0, 0, 0, 3, 0);
    do_req(1'b1, 32'h0000_0200, 3'd2, 32'h1234_5678, 4'hF, acc);
    wait_resp(rc);
    repeat (3) @(negedge clk);
    chk("wr1_aw_count", 32'(n_aw - a0), 32'd1);
    chk("wr1_w_count", 32'(n_w - w0), 32'd1);
    chk("wr1_b_count", 32'(n_b - b0), 32'd1);
    chk("wr1_resp_count", 32'(n_resp - r0), 32'd1);
    chk("wr1_awaddr", last_awaddr, 32'h0000_0200);
    chk("wr1_wdata", last_wdata, 32'h1234_5678);
    chk("wr1_err", 32'(resp_err), 32'd0);
    chk("wr1_rdata_kept", resp_rdata, 32'hDEAD_BEEF);

    // wready ahead of awready, then both in the same cycle
    for (int t = 0; t < 2; t++) begin
      a0 = n_aw; w0 = n_w; b0 = n_b; r0 = n_resp;
      if (t == 0) set_knobs(0, 0, 3, 0, 1); else set_knobs(0, 0, 2, 2, 0);
      do_req(1'b1, 32'h0000_0300 + 32'(t * 4), 3'd2, 32'hA5A5_0000 + 32'(t), 4'h3, acc);
      wait_resp(rc);
      repeat (3) @(negedge clk);
      chk("wr2_aw_count", 32'(n_aw - a0), 32'd1);
      chk("wr2_w_count", 32'(n_w - w0), 32'd1);
      chk("wr2_b_count", 32'(n_b - b0), 32'd1);
      chk("wr2_resp_count", 32'(n_resp - r0), 32'd1);
    end

    // DECERR read followed by an OKAY read
    set_knobs(0, 1, 0, 0, 0);
    k_rresp = 3; k_rdata = 32'h0BAD_0BAD;
    do_req(1'b0, 32'h4000_0000, 3'd2, 32'd0, 4'd0, acc);
    wait_resp(rc);
    chk("decerr_err", 32'(resp_err), 32'd1);
    k_rresp = 0; k_rdata = 32'h0000_1111;
    do_req(1'b0, 32'h4000_0004, 3'd2, 32'd0, 4'd0, acc);
    wait_resp(rc);
    chk("okay_err", 32'(resp_err), 32'd0);
    chk("okay_rdata", resp_rdata, 32'h0000_1111);

    // reset while waiting for read data
    set_knobs(0, 8, 0, 0, 0);
    r0 = n_resp;
    do_req(1'b0, 32'h5000_0000, 3'd2, 32'd0, 4'd0, acc);
    gap_ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.rready) begin gap_ok = 1; break; end
    end
    chk("rst_reach_rd_data", 32'(gap_ok), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid},
        32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rdata", resp_rdata, 32'd0);
    repeat (12) @(negedge clk);
    chk("rst_no_resp", 32'(n_resp - r0), 32'd0);

    // request held high: one accept per completion, four cycles apart
    set_knobs(0, 0, 0, 0, 0);
    r0 = n_resp;
    hold_valid = 1'b1;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_addr = 32'h6000_0000; req_size = 3'd2; req_valid = 1'b1;
    prev = -1;
    for (int n = 0; n < 5; n++) begin
      acc = -1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (req_ready) begin acc = cyc; break; end
      end
      if (acc < 0) chk("hold_accept_timeout", 32'd0, 32'd1);
      if (prev >= 0) chk("hold_accept_gap", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    hold_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_resp_count", 32'(n_resp - r0), 32'd5);

    // random traffic against the model
    set_knobs(-1, -1, -1, -1, -1);
    k_rresp = -1; k_bresp = -1; k_rdata_en = 0;
    r0 = n_resp; acc0 = n_acc;
    for (int t = 0; t < 250; t++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 2)), $urandom,
             4'($urandom), acc);
    end
    repeat (30) @(negedge clk);
    chk("rand_resp_count", 32'(n_resp - r0), 32'(n_acc - acc0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
